// File: rtl/booth_mul_ctrl.sv
// ---------------------------------------------------------------------------
// booth_mul_ctrl
//
// Sequential signed (two's complement) multiplier. A radix-2 Booth state
// machine drives one shared DATA_SIZE+1-bit add/subtract datapath, with
// subtraction done by inverting the operand and setting carry-in. A full
// product of 2*DATA_SIZE bits is ready DATA_SIZE cycles after start is
// accepted.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start_i; P_o holds the last result
//   ST_CALC | one Booth step per clock; busy_o high
//   ST_DONE | one cycle; done_o high and P_o freshly updated; start_i
//           | may launch the next operation directly
//
// Ports:
//   clk_i    in   1            rising-edge clock
//   rst_i    in   1            synchronous, active-high reset
//   start_i  in   1            start request, sampled in IDLE or DONE only
//   A_i      in   DATA_SIZE    signed multiplicand, latched on start
//   B_i      in   DATA_SIZE    signed multiplier, latched on start
//   busy_o   out  1            high while in CALC
//   done_o   out  1            one-cycle pulse when P_o has a new result
//   P_o      out  2*DATA_SIZE  signed product, held until the next result
// ---------------------------------------------------------------------------
module booth_mul_ctrl #(
    parameter int DATA_SIZE = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [DATA_SIZE-1:0]     A_i,
    input  logic [DATA_SIZE-1:0]     B_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2*DATA_SIZE-1:0]   P_o
);

    localparam int CW = $clog2(DATA_SIZE + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [DATA_SIZE:0]       r_m;
    logic [DATA_SIZE:0]       r_acc;
    logic [DATA_SIZE-1:0]     r_q;
    logic                     r_qm1;
    logic [CW-1:0]            r_cnt;
    logic [2*DATA_SIZE-1:0]   r_p;

    logic                     w_start_ok;
    logic                     w_last;
    logic [1:0]               w_sel;
    logic                     w_op_en;
    logic                     w_mode;
    logic [DATA_SIZE:0]       w_b_opnd;
    logic [DATA_SIZE:0]       w_sum;
    logic [DATA_SIZE:0]       w_acc_t;
    logic [2*DATA_SIZE+1:0]   w_shift;
    logic [DATA_SIZE:0]       w_acc_sh;
    logic [DATA_SIZE-1:0]     w_q_sh;
    logic                     w_qm1_sh;
    logic [2*DATA_SIZE-1:0]   w_prod;

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_start_ok = 1'b0;
        w_last     = 1'b0;
        w_start_ok = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_last     = (r_cnt == CW'(1));
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = w_start_ok ? ST_CALC : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Booth step datapath
    // -----------------------------------------------------------------------
    always_comb begin
        w_sel    = {r_q[0], r_qm1};
        // Only the 01 and 10 pairs touch the adder; 10 subtracts.
        w_op_en  = w_sel[1] ^ w_sel[0];
        w_mode   = (w_sel == 2'b10);
        w_b_opnd = r_m ^ {(DATA_SIZE + 1){w_mode}};
        // Carry-out falls off the top; the guard bit makes overflow impossible.
        w_sum    = r_acc + w_b_opnd + {{DATA_SIZE{1'b0}}, w_mode};
        w_acc_t  = w_op_en ? w_sum : r_acc;

        // Arithmetic right shift of {ACC_t, Q, q_m1}: the old q_m1 drops out.
        w_shift  = {w_acc_t[DATA_SIZE], w_acc_t, r_q};
        w_acc_sh = w_shift[2*DATA_SIZE+1:DATA_SIZE+1];
        w_q_sh   = w_shift[DATA_SIZE:1];
        w_qm1_sh = w_shift[0];

        // Guard bit of ACC is redundant sign here and is not part of the product.
        w_prod   = {w_acc_sh[DATA_SIZE-1:0], w_q_sh};
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_start_ok) begin
            r_m   <= {A_i[DATA_SIZE-1], A_i};
            r_acc <= '0;
            r_q   <= B_i;
            r_qm1 <= 1'b0;
            r_cnt <= CW'(DATA_SIZE);
        end else if (r_state == ST_CALC) begin
            r_acc <= w_acc_sh;
            r_q   <= w_q_sh;
            r_qm1 <= w_qm1_sh;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_p <= w_prod;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from the state register, so never glitch and never
    // overlap.
    // -----------------------------------------------------------------------
    assign busy_o = (r_state == ST_CALC);
    assign done_o = (r_state == ST_DONE);
    assign P_o    = r_p;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_ctrl
//
// Bench for booth_mul_ctrl (DATA_SIZE = 8). Expected products come from plain
// signed integer multiplication; handshake timing is checked against the
// start/busy/done cycle counts.
// ---------------------------------------------------------------------------
module tb_booth_mul_ctrl;

    localparam int DS = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [DS-1:0]   a;
    logic [DS-1:0]   b;
    logic            busy;
    logic            done;
    logic [2*DS-1:0] p;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;
    logic [2*DS-1:0] prev_p;

    typedef struct {
        logic [DS-1:0]   a;
        logic [DS-1:0]   b;
        logic [2*DS-1:0] p;
        string           name;
    } vec_t;

    vec_t vecs[7];

    booth_mul_ctrl #(.DATA_SIZE(DS)) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .A_i     (a),
        .B_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .P_o     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy && done) overlap++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*DS-1:0] model(input logic [DS-1:0] x, input logic [DS-1:0] y);
        int r;
        r = int'($signed(x)) * int'($signed(y));
        return r[2*DS-1:0];
    endfunction

    // Called at the negedge just after the accepting edge. Returns at the
    // negedge where done is seen (or the bound expires).
    task automatic wait_done(output int cyc, output int busy_cnt, output logic p_moved);
        cyc      = 0;
        busy_cnt = 0;
        p_moved  = 1'b0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (p !== prev_p) p_moved = 1'b1;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_op(input logic [DS-1:0] x, input logic [DS-1:0] y,
                         input logic [2*DS-1:0] exp, input string name);
        int   cyc;
        int   bc;
        logic pm;
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = DS'($urandom);
        b     = DS'($urandom);
        wait_done(cyc, bc, pm);
        chk({name, "_latency"}, cyc, DS);
        chk({name, "_busy_cycles"}, bc, DS);
        chk({name, "_p_held"}, {31'd0, pm}, 32'd0);
        chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_product"}, p, exp);
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        prev_p = exp;
    endtask

    initial begin
        int   cyc;
        int   bc;
        int   dcnt;
        logic pm;
        logic [DS-1:0] rx;
        logic [DS-1:0] ry;

        vecs[0] = '{8'h03, 8'h05, 16'h000F, "p3x5"};
        vecs[1] = '{8'hFD, 8'h05, 16'hFFF1, "m3x5"};
        vecs[2] = '{8'h05, 8'hFD, 16'hFFF1, "p5xm3"};
        vecs[3] = '{8'h80, 8'h80, 16'h4000, "minxmin"};
        vecs[4] = '{8'h80, 8'h7F, 16'hC080, "minxmax"};
        vecs[5] = '{8'h7F, 8'h7F, 16'h3F01, "maxxmax"};
        vecs[6] = '{8'h00, 8'hFF, 16'h0000, "zeroxm1"};

        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        prev_p = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_p", p, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);
        end

        // start held high through DONE: second operation launches back-to-back
        @(negedge clk);
        start = 1'b1;
        a     = 8'd6;
        b     = 8'd7;
        @(negedge clk);
        repeat (3) @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        wait_done(cyc, bc, pm);
        chk("hold_first_latency", cyc, DS - 3);
        chk("hold_first_product", p, 32'h002A);
        prev_p = 16'h002A;
        @(negedge clk);
        start = 1'b0;
        chk("hold_restart_busy", {31'd0, busy}, 32'd1);
        chk("hold_restart_done", {31'd0, done}, 32'd0);
        wait_done(cyc, bc, pm);
        chk("hold_second_latency", cyc, DS);
        chk("hold_second_product", p, 32'h0001);
        @(negedge clk);
        chk("hold_idle_busy", {31'd0, busy}, 32'd0);
        chk("hold_idle_done", {31'd0, done}, 32'd0);
        prev_p = 16'h0001;

        // reset in the middle of CALC aborts without a done pulse
        @(negedge clk);
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_p", p, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        chk("abort_no_activity", dcnt, 0);
        prev_p = '0;
        do_op(8'd2, 8'hFC, 16'hFFF8, "after_abort");

        for (int i = 0; i < 40; i++) begin
            rx = DS'($urandom);
            ry = DS'($urandom);
            do_op(rx, ry, model(rx, ry), "rand");
        end

        chk("busy_done_exclusive", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mul_ctrl.md
Name: booth_mul_ctrl

Overview:
- Sequential signed (two's complement) multiplier built around the team's add/subtract datapath style: one shared DATA_SIZE+1-bit adder with a mode bit (mode=0 add, mode=1 subtract via B inverted and carry-in = 1).
- Sequences that adder with a radix-2 Booth state machine.
- Uses a start/busy/done handshake and produces one 2*DATA_SIZE-bit product per operation.
- Sits beside the combinational add/sub unit as the multiply engine of the arithmetic block.

Parameters:
- DATA_SIZE, 8, operand width in bits (>= 2); product width is 2*DATA_SIZE.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request a new multiply; sampled only in IDLE or DONE.
- A_i  input  DATA_SIZE  signed multiplicand; latched when start is accepted.
- B_i  input  DATA_SIZE  signed multiplier; latched when start is accepted.
- busy_o  output  1  high while the operation is in progress (state CALC).
- done_o  output  1  one-cycle pulse: P_o has just been updated with a new result.
- P_o  output  2*DATA_SIZE  signed product; holds its value until the next result or reset.

Behaviour:
- Reset: rst_i high at a rising edge forces state=IDLE, busy_o=0, done_o=0, P_o=0, and clears all internal registers.
  - Reset has priority over every other event, including mid-CALC; an aborted operation never produces done_o.
- States: IDLE, CALC, DONE.
- Start acceptance: in IDLE or DONE, start_i=1 at an edge:
  - M <= sign-extended A_i (DATA_SIZE+1 bits).
  - ACC <= 0 (DATA_SIZE+1 bits).
  - Q <= B_i.
  - q_m1 <= 0.
  - cnt <= DATA_SIZE.
  - state <= CALC.
- start_i in CALC: ignored; no restart, no queueing.
- A_i and B_i changes after acceptance have no effect.
- CALC, one Booth step per edge, selected by {Q[0], q_m1}:
  - 01: ACC_t = ACC + M (mode 0).
  - 10: ACC_t = ACC - M (mode 1).
  - 00 or 11: ACC_t = ACC.
  - Then arithmetic right shift of {ACC_t, Q, q_m1} by 1 (MSB of ACC_t replicated).
  - cnt decrements by 1.
- The adder is DATA_SIZE+1 bits wide; the carry-out is discarded. The extra bit guarantees no overflow for any input pair, including A = -2^(DATA_SIZE-1).
- At the step where cnt goes 1 -> 0: P_o <= low 2*DATA_SIZE bits of {ACC, Q} after the shift, and state <= DONE.
- DONE: done_o=1 for exactly one cycle.
  - Next edge: state <= IDLE, or state <= CALC if start_i=1 (back-to-back operation with a new latch).
- Timing: start accepted at edge t0. CALC steps occur at edges t1..tN (N=DATA_SIZE). P_o updates and done_o rises at tN; done_o falls at tN+1.
- busy_o is high from t0 to tN.
- Outputs are registered; busy_o and done_o are decoded from state and are never high in the same cycle.
- P_o is unchanged during CALC; the previous result stays visible until tN.

Test Plan:
- Reset, then A=3, B=5, single-cycle start → busy_o high for 8 cycles; done_o pulses at edge 8 after start; P_o=0x000F.
- A=0xFD (-3), B=0x05 → P_o=0xFFF1 (-15). A=0x05, B=0xFD → also 0xFFF1.
- Corner operands:
  - A=0x80, B=0x80 → 0x4000.
  - A=0x80, B=0x7F → 0xC080.
  - A=0x7F, B=0x7F → 0x3F01.
  - A=0x00, B=0xFF → 0x0000.
- A=6, B=7 with start_i held high; mid-CALC drive A=B=0xFF → P_o=0x002A, one done_o pulse. Because start_i is still high in DONE, a second operation using A=B=0xFF starts and yields P_o=0x0001 (-1 × -1) with a second done_o pulse.
- Start A=9, B=9, assert rst_i at the 4th CALC edge:
  - Next cycle: busy_o=0, done_o=0, P_o=0, state IDLE.
  - No done_o pulse ever appears for the aborted operation.
  - A fresh start of 2×(-4) gives P_o=0xFFF8.
